gemm_cmd_sequencer: RTL and testbench
=====================================

Name: gemm_cmd_sequencer

Overview:
Queues GEMM commands from a host-side source and issues them one at a time to the gemm_processor datapath. Handles per-command repeat counts and waits for engine completion between issues. Sits between the host/bring-up logic (buttons, cocotb driver) and gemm_processor. It also exports a retired-command count and sticky status for LEDs and the bench.

Parameters:
- DEPTH, 8, command FIFO entries; power of two, minimum 2.
- CMD_W, 8, width of the engine command word.
- TIMEOUT, 1024, watchdog limit in cycles; used only with GEMM_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  host command valid
- in_ready  out  1  FIFO can accept an entry
- in_cmd  in  CMD_W  command word; bits [CMD_W-1:CMD_W-2] are the opcode; opcode 00 = NOP
- in_repeat  in  4  extra executions; the entry runs in_repeat+1 times
- flush  in  1  drop all queued entries
- eng_cmd  out  CMD_W  command presented to gemm_processor
- eng_start  out  1  one-cycle start pulse
- eng_done  in  1  one-cycle completion pulse from the engine
- busy  out  1  FSM is not in IDLE, or the FIFO is non-empty
- retired  out  16  count of completed executions; wraps
- error  out  1  sticky fault flag

Behaviour:
Reset values:
- FIFO empty; in_ready=1; eng_cmd=0; eng_start=0; busy=0; retired=0; error=0; FSM in IDLE.
- Reset asserted mid-operation aborts everything immediately; no pulse is emitted afterwards.

FIFO:
- Write when in_valid && in_ready. in_ready = !full.
- Each entry stores {in_cmd, in_repeat}.
- Full at DEPTH entries; a write while full is impossible by handshake.
- flush empties the FIFO on the next edge and does not abort the command in flight.
- flush has priority over a simultaneous write; the written entry is dropped.

FSM states: IDLE, LOAD, ISSUE, WAIT.
- IDLE: if FIFO non-empty (and no flush this cycle), go to LOAD.
- LOAD: pop the head into cur_cmd/cur_rep.
  - If the opcode is NOP: retired += cur_rep+1 in one step, then go to IDLE. No eng_start is issued.
  - Otherwise go to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; eng_cmd=cur_cmd; go to WAIT.
- WAIT:
  - eng_cmd is held stable. eng_done is sampled only in WAIT.
  - On eng_done: retired += 1.
  - If cur_rep != 0: decrement cur_rep and go to ISSUE.
  - If cur_rep == 0: go to LOAD when the FIFO is non-empty, else go to IDLE.
- eng_done outside WAIT sets error=1 and is otherwise ignored.

Timing:
- Minimum latency from a write into an empty FIFO to eng_start is 3 cycles: write edge, IDLE→LOAD, LOAD→ISSUE.
- Back-to-back reissue: eng_start occurs 1 cycle after the eng_done cycle.
- eng_cmd holds its last value in IDLE.

Arithmetic:
- retired is 16-bit modulo; 0xFFFF+1 = 0x0000 with no error.

Simultaneous events:
- A FIFO write and pop in the same cycle are both honoured; occupancy is unchanged.

Optional Feature:
Macro: GEMM_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without eng_done, the FSM aborts the current entry, discarding the remaining repeats.
  - error is set to 1 and retired is not incremented.
  - The FSM then goes to LOAD or IDLE as after a normal completion.
- Not defined:
  - WAIT waits indefinitely; no counter logic is synthesised.
  - error can still be set by a stray eng_done.

Test Plan:
1. Reset, then write cmd=0x41 with repeat=0; engine returns done 5 cycles after start. Required: eng_start exactly once, 3 cycles after the write; eng_cmd=0x41 throughout WAIT; retired=1; busy=0 afterwards; error=0.
2. Write cmd=0x82 with repeat=3; engine done 2 cycles after each start. Required: 4 eng_start pulses, each 1 cycle after the preceding done; retired=4.
3. Write DEPTH+1 entries while the engine is stalled. Required: in_ready=0 after 8 queued entries (the 9th is accepted once the head pops); on release, all 9 complete in FIFO order.
4. Queue NOP (cmd=0x00, repeat=2) followed by cmd=0x40. Required: no eng_start for the NOP; retired jumps by 3; then one eng_start with eng_cmd=0x40.
5. Queue 3 entries, then assert flush during WAIT of the first. Required: the first completes (retired=1); no further starts; a stray eng_done in IDLE sets error=1.
6. With GEMM_SEQ_TIMEOUT_EN and TIMEOUT=16, start cmd=0x40 with repeat=2 and never assert done. Required: error=1 after 16 WAIT cycles; repeats are discarded; retired=0; FSM returns to IDLE.

Source files
------------

// File: rtl/gemm_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// gemm_cmd_sequencer
//
// Queues GEMM commands from a host-side source and issues them one at a time
// to the gemm_processor datapath. Each queued entry runs (repeat + 1) times;
// opcode 00 entries are NOPs that only retire. A retired-execution count and
// a sticky error flag are exported for LEDs and the bench.
//
// Optional feature macro: GEMM_SEQ_TIMEOUT_EN
//   Defined     : watchdog aborts an entry stuck in WAIT for TIMEOUT cycles.
//   Not defined : WAIT waits indefinitely; no watchdog logic.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   in_valid   host command valid
//   in_ready   FIFO can accept an entry
//   in_cmd     command word, [CMD_W-1:CMD_W-2] = opcode, 00 = NOP
//   in_repeat  extra executions (entry runs in_repeat+1 times)
//   flush      drop all queued entries (in-flight command continues)
//   eng_cmd    command presented to gemm_processor
//   eng_start  one-cycle start pulse
//   eng_done   one-cycle completion pulse from the engine
//   busy       FSM not idle or FIFO non-empty
//   retired    count of completed executions, wraps at 16 bits
//   error      sticky fault flag
// -----------------------------------------------------------------------------
module gemm_cmd_sequencer #(
  parameter int DEPTH   = 8,
  parameter int CMD_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic [3:0]       in_repeat,
  input  logic             flush,
  output logic [CMD_W-1:0] eng_cmd,
  output logic             eng_start,
  input  logic             eng_done,
  output logic             busy,
  output logic [15:0]      retired,
  output logic             error
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CMD_W + 4;

  // Elaboration-time sanity check of the configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("gemm_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [CMD_W-1:0] cur_cmd_q, cur_cmd_d;
  logic [3:0]       cur_rep_q, cur_rep_d;
  logic [15:0]      retired_q, retired_d;
  logic             error_q, error_d;
  logic             start_q, start_d;

  logic             fifo_empty_s;
  logic             wr_en_s;
  logic             pop_s;
  logic [EW-1:0]    head_s;
  logic [CMD_W-1:0] head_cmd_s;
  logic [3:0]       head_rep_s;
  logic             head_nop_s;

  assign fifo_empty_s = (count_q == '0);
  assign in_ready     = (count_q != (AW+1)'(DEPTH));
  // flush wins over a simultaneous write: the written entry is dropped.
  assign wr_en_s      = in_valid && in_ready && !flush;
  assign head_s       = mem_q[rd_ptr_q];
  assign head_cmd_s   = head_s[EW-1:4];
  assign head_rep_s   = head_s[3:0];
  assign head_nop_s   = (head_cmd_s[CMD_W-1 -: 2] == 2'b00);

  // Command storage; contents need no reset, occupancy is tracked by pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {in_cmd, in_repeat};
    end
  end

  // FIFO pointers and occupancy; a pop in the flush cycle still used the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
    end
  end

`ifdef GEMM_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wdog_q, wdog_d;

  // Watchdog counter for cycles spent in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_cmd_q <= '0;
      cur_rep_q <= 4'd0;
      retired_q <= 16'd0;
      error_q   <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_cmd_q <= cur_cmd_d;
      cur_rep_q <= cur_rep_d;
      retired_q <= retired_d;
      error_q   <= error_d;
      start_q   <= start_d;
    end
  end

  // Next-state logic; start_d is raised on every transition into ISSUE so the
  // registered start pulse coincides exactly with the ISSUE cycle.
  always_comb begin
    state_d   = state_q;
    cur_cmd_d = cur_cmd_q;
    cur_rep_d = cur_rep_q;
    retired_d = retired_q;
    error_d   = error_q;
    start_d   = 1'b0;
    pop_s     = 1'b0;
`ifdef GEMM_SEQ_TIMEOUT_EN
    wdog_d    = wdog_q;
`endif

    // A completion pulse is only meaningful while waiting for one.
    if (eng_done && (state_q != S_WAIT)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s && !flush) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          cur_rep_d = head_rep_s;
          if (head_nop_s) begin
            retired_d = retired_q + 16'(head_rep_s) + 16'd1;
            state_d   = S_IDLE;
          end else begin
            cur_cmd_d = head_cmd_s;
            start_d   = 1'b1;
            state_d   = S_ISSUE;
          end
        end else begin
          // Queue was flushed underneath us.
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef GEMM_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end

      S_WAIT: begin
        if (eng_done) begin
          retired_d = retired_q + 16'd1;
          if (cur_rep_q != 4'd0) begin
            cur_rep_d = cur_rep_q - 4'd1;
            start_d   = 1'b1;
            state_d   = S_ISSUE;
          end else if (!fifo_empty_s && !flush) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
`ifdef GEMM_SEQ_TIMEOUT_EN
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          // Abort the entry: remaining repeats discarded, nothing retired.
          error_d   = 1'b1;
          cur_rep_d = 4'd0;
          if (!fifo_empty_s && !flush) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          wdog_d  = wdog_q + TW'(1);
          state_d = S_WAIT;
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign eng_cmd   = cur_cmd_q;
  assign eng_start = start_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty_s;
  assign retired   = retired_q;
  assign error     = error_q;

endmodule

// File: tb/tb_gemm_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for gemm_cmd_sequencer. A behavioural engine responds to
// eng_start with eng_done after a (possibly random) delay; a reference model
// holds the expected sequence of issued commands and the expected retired
// total, both derived from the accepted writes.
// -----------------------------------------------------------------------------
module tb_gemm_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int CMD_W = 8;
`ifdef GEMM_SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CMD_W-1:0] in_cmd = '0;
  logic [3:0]       in_repeat = 4'd0;
  logic             flush = 1'b0;
  logic [CMD_W-1:0] eng_cmd;
  logic             eng_start;
  logic             eng_done;
  logic             eng_done_r = 1'b0;
  logic             stray_done = 1'b0;
  logic             busy;
  logic [15:0]      retired;
  logic             error;

  assign eng_done = eng_done_r | stray_done;

  gemm_cmd_sequencer #(.DEPTH(DEPTH), .CMD_W(CMD_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_repeat(in_repeat), .flush(flush),
    .eng_cmd(eng_cmd), .eng_start(eng_start), .eng_done(eng_done),
    .busy(busy), .retired(retired), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [CMD_W-1:0] exp_q[$];
  logic [15:0]      exp_retired = 16'd0;
  int               starts = 0;
  int               last_done_cyc = 0;
  int               wr_cyc = 0;
  bit               b2b_chk = 1'b0;
  int               b2b_n = 0;

  // Engine model controls
  int               eng_delay = 3;
  bit               eng_rand = 1'b0;
  bit               stall = 1'b0;
  bit               eng_busy = 1'b0;

  // Monitor: every start must present the next expected command.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && eng_start) begin
        check("start_queue", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("start_cmd", eng_cmd, exp_q.pop_front());
        if (b2b_chk && b2b_n > 0) check("reissue_gap", cyc - last_done_cyc, 1);
        if (b2b_chk) b2b_n++;
        starts++;
      end
    end
  end

  // Engine: done pulse d cycles after a start (counting pauses while stalled).
  initial begin
    int cnt;
    int d;
    logic [CMD_W-1:0] cmd_at_start;
    cnt = 0; d = 1; cmd_at_start = '0;
    forever begin
      @(negedge clk);
      eng_done_r = 1'b0;
      if (reset) begin
        eng_busy = 1'b0;
      end else if (eng_busy) begin
        if (!stall) cnt++;
        if (cnt >= d && !stall) begin
          check("wait_cmd_hold", eng_cmd, cmd_at_start);
          eng_done_r = 1'b1;
          last_done_cyc = cyc;
          eng_busy = 1'b0;
        end
      end else if (eng_start) begin
        eng_busy = 1'b1;
        cnt = 0;
        d = eng_rand ? int'($urandom_range(1, 6)) : eng_delay;
        cmd_at_start = eng_cmd;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_eng_cmd", eng_cmd, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_busy", busy, 0);
    check("rst_retired", retired, 0);
    check("rst_error", error, 0);
    exp_q.delete();
    exp_retired = 16'd0;
    starts = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one entry for one cycle; the model learns it only if accepted.
  task automatic push_cmd(input logic [CMD_W-1:0] c, input logic [3:0] r, output bit ok);
    in_valid = 1'b1;
    in_cmd = c;
    in_repeat = r;
    ok = in_ready && !flush;
    wr_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    if (ok) begin
      exp_retired += 16'(r) + 16'd1;
      if (c[CMD_W-1 -: 2] != 2'b00) begin
        for (int i = 0; i <= int'(r); i++) exp_q.push_back(c);
      end
    end
  endtask

  task automatic push_retry(input logic [CMD_W-1:0] c, input logic [3:0] r);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 300) begin
      push_cmd(c, r, ok);
      n++;
    end
    check("push_accept", ok, 1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!eng_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, eng_start, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((busy || eng_busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, (n < 3000) && !busy, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int s0;
    int s_cyc;
    logic [15:0] base;
    logic [CMD_W-1:0] c;

    do_reset();

    // 1: single command, latency and hold
    eng_delay = 5;
    push_cmd(8'h41, 4'd0, ok);
    wait_start("t1_start");
    check("t1_latency", cyc - wr_cyc, 3);
    wait_drain("t1_drain");
    check("t1_retired", retired, exp_retired);
    check("t1_starts", starts, 1);
    check("t1_busy", busy, 0);
    check("t1_error", error, 0);
    check("t1_idle_hold", eng_cmd, 8'h41);

    // 2: repeats reissue one cycle after each done
    eng_delay = 2;
    b2b_chk = 1'b1;
    b2b_n = 0;
    s0 = starts;
    push_cmd(8'h82, 4'd3, ok);
    wait_drain("t2_drain");
    b2b_chk = 1'b0;
    check("t2_starts", starts - s0, 4);
    check("t2_retired", retired, exp_retired);

    // 3: fill the FIFO behind a stalled engine
    eng_delay = 1;
    stall = 1'b1;
    push_cmd(8'h43, 4'd0, ok);
    wait_start("t3_first_start");
    for (int i = 0; i < DEPTH; i++) begin
      push_cmd(8'h50 + 8'(i), 4'd0, ok);
      check("t3_accept", ok, 1);
    end
    check("t3_full", in_ready, 0);
    push_cmd(8'h60, 4'd0, ok);
    check("t3_reject", ok, 0);
    stall = 1'b0;
    wait_drain("t3_drain");
    check("t3_retired", retired, exp_retired);

    // 4: NOP retires in one step without a start
    base = exp_retired;
    s0 = starts;
    push_cmd(8'h00, 4'd2, ok);
    push_cmd(8'h40, 4'd0, ok);
    wait_start("t4_start");
    check("t4_nop_jump", retired, base + 16'd3);
    wait_drain("t4_drain");
    check("t4_starts", starts - s0, 1);
    check("t4_retired", retired, exp_retired);

    // 5: flush during WAIT keeps the in-flight command
    do_reset();
    eng_delay = 4;
    push_cmd(8'h44, 4'd0, ok);
    push_cmd(8'h45, 4'd0, ok);
    push_cmd(8'h46, 4'd0, ok);
    wait_start("t5_start");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    exp_retired -= 16'd2;
    wait_drain("t5_drain");
    check("t5_retired", retired, 16'd1);
    check("t5_starts", starts, 1);
    check("t5_error_clean", error, 0);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("t5_stray_error", error, 1);

    // Reset mid-operation aborts everything
    do_reset();
    eng_delay = 6;
    push_cmd(8'h47, 4'd3, ok);
    wait_start("rm_start");
    repeat (2) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    check("rm_no_start", starts, 0);
    check("rm_error", error, 0);
    check("rm_retired", retired, 0);

    // Randomized traffic against the model
    do_reset();
    eng_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c = CMD_W'($urandom);
      if ($urandom_range(0, 4) == 0) c[CMD_W-1 -: 2] = 2'b00;
      push_retry(c, 4'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("rnd_drain");
    eng_rand = 1'b0;
    check("rnd_retired", retired, exp_retired);
    check("rnd_error", error, 0);
    check("rnd_queue_empty", exp_q.size(), 0);

`ifdef GEMM_SEQ_TIMEOUT_EN
    // 6: watchdog abort after TMO WAIT cycles
    do_reset();
    stall = 1'b1;
    push_cmd(8'h40, 4'd2, ok);
    wait_start("t6_start");
    s_cyc = cyc;
    repeat (TMO) @(negedge clk);
    check("t6_error_before", error, 0);
    @(negedge clk);
    check("t6_error_after", error, 1);
    check("t6_elapsed", cyc - s_cyc, TMO + 1);
    repeat (4) @(negedge clk);
    check("t6_busy", busy, 0);
    check("t6_retired", retired, 0);
    check("t6_starts", starts, 1);
    do_reset();
    stall = 1'b0;
`else
    s_cyc = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
